// File: rtl/core_reg_bank.sv
// core_reg_bank: configurable register bank for the matrix-multiply cores.
// Each register can be loaded from the shared bus, cleared, incremented,
// decremented, or loaded-and-incremented in a single edge. The bus and the
// memory pointer outputs are combinational. Two registered equality flags
// compare fixed register pairs.
module core_reg_bank #(
   parameter int DATA_W    = 8,
   parameter int NUM_REGS  = 14,
   parameter int SEL_W     = 4,
   parameter int PTR_BASE  = 0,
   parameter int NUM_PTR   = 4,
   parameter int PTR_SEL_W = 2,
   parameter int SAT       = 0,
   parameter int CMP_A0    = 10,
   parameter int CMP_B0    = 11,
   parameter int CMP_A1    = 7,
   parameter int CMP_B1    = 8
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic [NUM_REGS-1:0]          WRT_en,
   input  logic [NUM_REGS-1:0]          INC_en,
   input  logic [NUM_REGS-1:0]          DEC_en,
   input  logic [NUM_REGS-1:0]          CLR_en,
   input  logic [NUM_REGS-1:0]          LDI_en,
   input  logic [DATA_W-1:0]            Ddin,
   input  logic [SEL_W-1:0]             Bus_Select,
   input  logic [PTR_SEL_W-1:0]         PCtrl,
   output logic [DATA_W-1:0]            BUSo,
   output logic [DATA_W-1:0]            DAddress,
   output logic                         Z1,
   output logic                         Z2,
   output logic [NUM_REGS*DATA_W-1:0]   REGS_flat
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              z1_d;
   logic              z2_d;

   // Reject configurations whose selects or compare indices cannot address the bank.
   generate
      if ((1 << SEL_W) < NUM_REGS + 1) begin : g_bad_sel_w
         $error("core_reg_bank: SEL_W too narrow for NUM_REGS+1 bus slots");
      end
      if ((1 << PTR_SEL_W) < NUM_PTR) begin : g_bad_ptr_sel_w
         $error("core_reg_bank: PTR_SEL_W too narrow for NUM_PTR");
      end
      if (PTR_BASE < 0 || NUM_PTR < 1 || PTR_BASE + NUM_PTR > NUM_REGS) begin : g_bad_ptr
         $error("core_reg_bank: pointer window exceeds register bank");
      end
      if (CMP_A0 < 0 || CMP_A0 >= NUM_REGS || CMP_B0 < 0 || CMP_B0 >= NUM_REGS) begin : g_bad_cmp0
         $error("core_reg_bank: compare pair 0 index out of range");
      end
      if (CMP_A1 < 0 || CMP_A1 >= NUM_REGS || CMP_B1 < 0 || CMP_B1 >= NUM_REGS) begin : g_bad_cmp1
         $error("core_reg_bank: compare pair 1 index out of range");
      end
   endgenerate

   // Increment that either wraps or sticks at all-ones depending on SAT.
   function automatic logic [DATA_W-1:0] inc_val(input logic [DATA_W-1:0] v);
      if ((SAT != 0) && (v == {DATA_W{1'b1}})) return v;
      return v + DATA_W'(1);
   endfunction

   // Decrement that either wraps or sticks at zero depending on SAT.
   function automatic logic [DATA_W-1:0] dec_val(input logic [DATA_W-1:0] v);
      if ((SAT != 0) && (v == '0)) return v;
      return v - DATA_W'(1);
   endfunction

   // Bus multiplexer: slot 0 is memory data, slot k is register k-1, unused slots read zero.
   always_comb begin
      BUSo = '0;
      if (Bus_Select == '0) begin
         BUSo = Ddin;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(Bus_Select) == r + 1) BUSo = regs_q[r];
         end
      end
   end

   // Pointer multiplexer: selects within the pointer window, zero outside it.
   always_comb begin
      DAddress = '0;
      for (int p = 0; p < NUM_PTR; p++) begin
         if (int'(PCtrl) == p) DAddress = regs_q[PTR_BASE + p];
      end
   end

   // Per-register next value; clear beats write beats load-increment beats inc/dec.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (CLR_en[r]) begin
            regs_d[r] = '0;
         end else if (WRT_en[r]) begin
            regs_d[r] = BUSo;
         end else if (LDI_en[r]) begin
            regs_d[r] = inc_val(BUSo);
         end else if (INC_en[r] && DEC_en[r]) begin
            regs_d[r] = regs_q[r];
         end else if (INC_en[r]) begin
            regs_d[r] = inc_val(regs_q[r]);
         end else if (DEC_en[r]) begin
            regs_d[r] = dec_val(regs_q[r]);
         end
      end
   end

   // Equality flags are computed from the current contents and land one edge later.
   always_comb begin
      z1_d = (regs_q[CMP_A0] == regs_q[CMP_B0]);
      z2_d = (regs_q[CMP_A1] == regs_q[CMP_B1]);
   end

   // State update for the register array and flags, cleared asynchronously.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         Z1 <= 1'b0;
         Z2 <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
         Z1 <= z1_d;
         Z2 <= z2_d;
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
         assign REGS_flat[g*DATA_W +: DATA_W] = regs_q[g];
      end
   endgenerate

endmodule

// File: tb/tb_core_reg_bank.sv
// Testbench for core_reg_bank: a wrapping instance with four pointers and a
// saturating instance with three pointers share all inputs. Directed table
// rows, a mid-cycle reset, a flag-latency sequence and random traffic are
// checked against a behavioural model of the register bank.
module tb_core_reg_bank;

   logic         CLK;
   logic         RST_N;
   logic [13:0]  WRT_en, INC_en, DEC_en, CLR_en, LDI_en;
   logic [7:0]   Ddin;
   logic [3:0]   Bus_Select;
   logic [1:0]   PCtrl;

   logic [7:0]   bus0, bus1, da0, da1;
   logic         z1_0, z2_0, z1_1, z2_1;
   logic [111:0] flat0, flat1;

   int checks = 0;
   int errors = 0;

   core_reg_bank #(.SAT(0), .NUM_PTR(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .WRT_en(WRT_en), .INC_en(INC_en), .DEC_en(DEC_en), .CLR_en(CLR_en), .LDI_en(LDI_en),
      .Ddin(Ddin), .Bus_Select(Bus_Select), .PCtrl(PCtrl),
      .BUSo(bus0), .DAddress(da0), .Z1(z1_0), .Z2(z2_0), .REGS_flat(flat0)
   );

   core_reg_bank #(.SAT(1), .NUM_PTR(3)) dut_s (
      .CLK(CLK), .RST_N(RST_N),
      .WRT_en(WRT_en), .INC_en(INC_en), .DEC_en(DEC_en), .CLR_en(CLR_en), .LDI_en(LDI_en),
      .Ddin(Ddin), .Bus_Select(Bus_Select), .PCtrl(PCtrl),
      .BUSo(bus1), .DAddress(da1), .Z1(z1_1), .Z2(z2_1), .REGS_flat(flat1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural model ----------------
   // Index 0 = wrapping instance (4 pointers), index 1 = saturating instance (3 pointers).
   int m [2][14];
   bit mz1 [2];
   bit mz2 [2];

   function automatic int mbus(int k);
      int s;
      s = int'(Bus_Select);
      if (s == 0) return int'(Ddin);
      if (s <= 14) return m[k][s-1];
      return 0;
   endfunction

   function automatic int mdaddr(int k);
      int np;
      int p;
      np = (k == 0) ? 4 : 3;
      p = int'(PCtrl);
      if (p < np) return m[k][p];
      return 0;
   endfunction

   function automatic int minc(int k, int v);
      if (k == 1) return (v == 255) ? 255 : v + 1;
      return (v + 1) % 256;
   endfunction

   function automatic int mdec(int k, int v);
      if (k == 1) return (v == 0) ? 0 : v - 1;
      return (v + 255) % 256;
   endfunction

   function automatic logic [127:0] mflat(int k);
      logic [127:0] f;
      f = '0;
      for (int r = 0; r < 14; r++) f[r*8 +: 8] = 8'(m[k][r]);
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 14; r++) m[k][r] = 0;
         mz1[k] = 1'b0;
         mz2[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      int nm [2][14];
      for (int k = 0; k < 2; k++) begin
         int b;
         b = mbus(k);
         mz1[k] = (m[k][10] == m[k][11]);
         mz2[k] = (m[k][7] == m[k][8]);
         for (int r = 0; r < 14; r++) begin
            if (CLR_en[r])                  nm[k][r] = 0;
            else if (WRT_en[r])             nm[k][r] = b;
            else if (LDI_en[r])             nm[k][r] = minc(k, b);
            else if (INC_en[r] && DEC_en[r]) nm[k][r] = m[k][r];
            else if (INC_en[r])             nm[k][r] = minc(k, m[k][r]);
            else if (DEC_en[r])             nm[k][r] = mdec(k, m[k][r]);
            else                            nm[k][r] = m[k][r];
         end
      end
      m = nm;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [13:0] w, input logic [13:0] i, input logic [13:0] d,
                        input logic [13:0] c, input logic [13:0] l, input logic [7:0] din,
                        input logic [3:0] s, input logic [1:0] p);
      WRT_en = w; INC_en = i; DEC_en = d; CLR_en = c; LDI_en = l;
      Ddin = din; Bus_Select = s; PCtrl = p;
   endtask

   task automatic pre_checks();
      chk("bus_w", 128'(bus0), 128'(mbus(0)));
      chk("bus_s", 128'(bus1), 128'(mbus(1)));
      chk("daddr_w", 128'(da0), 128'(mdaddr(0)));
      chk("daddr_s", 128'(da1), 128'(mdaddr(1)));
   endtask

   task automatic post_checks();
      chk("regs_w", 128'(flat0), mflat(0));
      chk("regs_s", 128'(flat1), mflat(1));
      chk("z1_w", 128'(z1_0), 128'(mz1[0]));
      chk("z2_w", 128'(z2_0), 128'(mz2[0]));
      chk("z1_s", 128'(z1_1), 128'(mz1[1]));
      chk("z2_s", 128'(z2_1), 128'(mz2[1]));
   endtask

   // Inputs are expected to be driven already; call from just after a rising edge.
   task automatic step_checked();
      #1;
      pre_checks();
      @(posedge CLK);
      model_step();
      #1;
      post_checks();
   endtask

   function automatic logic [13:0] bit_of(int i);
      return 14'(1) << i;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic [13:0] wrt, inc, dec, clr, ldi;
      logic [7:0]  ddin;
      logic [3:0]  sel;
      logic [1:0]  pctrl;
      int          chk_r;
      logic [7:0]  exp_w, exp_s;   // checked register after the edge
      logic [7:0]  exp_bus;        // wrapping instance bus before the edge
      logic [7:0]  exp_da_w, exp_da_s;
   } vec_t;

   localparam logic [13:0] N = 14'd0;
   vec_t tbl [18];

   initial begin
      logic [13:0] w, i, d, c, l;

      tbl[0]  = '{bit_of(3), N, N, N, N, 8'h5A, 4'd0,  2'd0, 3, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00};
      tbl[1]  = '{bit_of(5), N, N, N, N, 8'h5A, 4'd4,  2'd0, 5, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00};
      tbl[2]  = '{N, N, N, N, N,         8'h5A, 4'd15, 2'd0, 5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00};
      tbl[3]  = '{bit_of(2), N, N, N, N, 8'h10, 4'd0,  2'd0, 2, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
      tbl[4]  = '{bit_of(2), bit_of(2), N, bit_of(2), N, 8'h77, 4'd0, 2'd0, 2, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00};
      tbl[5]  = '{N, bit_of(2), bit_of(2), N, N, 8'h77, 4'd0, 2'd0, 2, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00};
      tbl[6]  = '{bit_of(2), bit_of(2), N, N, N, 8'h33, 4'd0, 2'd0, 2, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00};
      tbl[7]  = '{bit_of(1), N, N, N, N, 8'hFF, 4'd0,  2'd0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
      tbl[8]  = '{N, bit_of(1), N, N, N, 8'h00, 4'd0,  2'd0, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      tbl[9]  = '{N, N, bit_of(1), N, N, 8'h00, 4'd0,  2'd0, 1, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00};
      tbl[10] = '{N, N, N, bit_of(1), N, 8'h00, 4'd0,  2'd0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[11] = '{N, N, bit_of(1), N, N, 8'h00, 4'd0,  2'd0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[12] = '{N, N, N, N, bit_of(1), 8'h20, 4'd0,  2'd0, 1, 8'h21, 8'h21, 8'h20, 8'h00, 8'h00};
      tbl[13] = '{N, N, N, N, N,         8'h00, 4'd2,  2'd1, 1, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
      tbl[14] = '{N, N, N, N, N,         8'h00, 4'd0,  2'd3, 3, 8'h5A, 8'h5A, 8'h00, 8'h5A, 8'h00};
      tbl[15] = '{N, N, N, N, bit_of(4), 8'hFF, 4'd0,  2'd0, 4, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
      tbl[16] = '{N, N, N, N, bit_of(4), 8'h00, 4'd5,  2'd0, 4, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
      tbl[17] = '{bit_of(3) | bit_of(6) | bit_of(7), N, N, N, N, 8'h00, 4'd4, 2'd0, 7, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00};

      // Reset state
      RST_N = 1'b0;
      drive(N, N, N, N, N, 8'h00, 4'd0, 2'd0);
      model_reset();
      #1;
      post_checks();
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // Directed table
      for (int t = 0; t < 18; t++) begin
         drive(tbl[t].wrt, tbl[t].inc, tbl[t].dec, tbl[t].clr, tbl[t].ldi,
               tbl[t].ddin, tbl[t].sel, tbl[t].pctrl);
         #1;
         pre_checks();
         chk($sformatf("tbl%0d_bus", t), 128'(bus0), 128'(tbl[t].exp_bus));
         chk($sformatf("tbl%0d_da_w", t), 128'(da0), 128'(tbl[t].exp_da_w));
         chk($sformatf("tbl%0d_da_s", t), 128'(da1), 128'(tbl[t].exp_da_s));
         @(posedge CLK);
         model_step();
         #1;
         post_checks();
         chk($sformatf("tbl%0d_reg_w", t), 128'(flat0[tbl[t].chk_r*8 +: 8]), 128'(tbl[t].exp_w));
         chk($sformatf("tbl%0d_reg_s", t), 128'(flat1[tbl[t].chk_r*8 +: 8]), 128'(tbl[t].exp_s));
      end

      // Mid-cycle asynchronous reset with nonzero registers and set flags
      drive(N, N, N, N, N, 8'h00, 4'd0, 2'd0);
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      chk("async_rst_regs_w", 128'(flat0), 128'(0));
      chk("async_rst_regs_s", 128'(flat1), 128'(0));
      chk("async_rst_z1", 128'(z1_0), 128'(0));
      chk("async_rst_z2", 128'(z2_0), 128'(0));
      #2;
      RST_N = 1'b1;
      step_checked();
      chk("post_rst_z1", 128'(z1_0), 128'(1));
      chk("post_rst_z2", 128'(z2_0), 128'(1));

      // Flag latency: equal pair, then increment one side
      drive(bit_of(10) | bit_of(11), N, N, N, N, 8'h04, 4'd0, 2'd0);
      step_checked();
      drive(N, bit_of(10), N, N, N, 8'h00, 4'd0, 2'd0);
      step_checked();
      chk("lag_reg10", 128'(flat0[80 +: 8]), 128'(8'h05));
      chk("lag_z1_edgeN", 128'(z1_0), 128'(1));
      drive(N, N, N, N, N, 8'h00, 4'd0, 2'd0);
      step_checked();
      chk("lag_z1_edgeN1", 128'(z1_0), 128'(0));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         w = 14'($urandom & $urandom & $urandom);
         i = 14'($urandom & $urandom);
         d = 14'($urandom & $urandom);
         c = 14'($urandom & $urandom & $urandom & $urandom);
         l = 14'($urandom & $urandom & $urandom);
         drive(w, i, d, c, l, 8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         step_checked();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
